// File: rtl/ofdm_pkg.sv
// Shared definitions for the OFDM frame path.
// Frame FSM states, default preamble/pad words, symbol geometry.
package ofdm_pkg;

  localparam int SYM_BITS = 32;
  localparam int N_SUBCAR = 64;

  localparam logic [SYM_BITS-1:0] PREAMBLE_WORD_DEF = 32'hA5A5_5A5A;
  localparam logic [SYM_BITS-1:0] PAD_WORD_DEF      = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_PAYLOAD,
    ST_PAD,
    ST_DRAIN,
    ST_DONE
  } frame_state_e;

endpackage

// File: rtl/axis_ofdm_frame_ctrl.sv
// Frame sequencer in front of the BPSK subcarrier mapper.
// Emits preamble, payload (padded to frame_len), then waits for symbols.
//
// Ports:
//   aclk, aresetn          clock, async active-low reset
//   start, abort           frame request (IDLE only), synchronous abort
//   frame_len              payload words, latched on accepted start
//   s_axis_*               upstream payload stream
//   m_axis_*               words to the mapper, tlast on last frame word
//   sym_done               one pulse per symbol finished by the mapper
//   busy, done, short_err  frame status
module axis_ofdm_frame_ctrl
  import ofdm_pkg::*;
#(
  parameter int unsigned          PREAMBLE_LEN  = 2,
  parameter logic [SYM_BITS-1:0]  PREAMBLE_WORD = PREAMBLE_WORD_DEF,
  parameter logic [SYM_BITS-1:0]  PAD_WORD      = PAD_WORD_DEF,
  parameter int unsigned          LEN_W         = 8
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                start,
  input  logic                abort,
  input  logic [LEN_W-1:0]    frame_len,
  input  logic [SYM_BITS-1:0] s_axis_tdata,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_tlast,
  output logic                s_axis_tready,
  output logic [SYM_BITS-1:0] m_axis_tdata,
  output logic                m_axis_tvalid,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready,
  input  logic                sym_done,
  output logic                busy,
  output logic                done,
  output logic                short_err
);

  localparam int CW = LEN_W + 1;
  localparam logic [CW-1:0] ONE      = 1;
  localparam logic [CW-1:0] PRE_LEN  = CW'(PREAMBLE_LEN);
  localparam logic [CW-1:0] PRE_LAST = CW'(PREAMBLE_LEN - 1);

  frame_state_e     state_q;
  logic [LEN_W-1:0] len_q;
  logic [CW-1:0]    wc_q;
  logic [CW-1:0]    sc_q;
  logic [CW-1:0]    sc_d;
  logic             busy_q;
  logic             done_q;
  logic             short_err_q;

  logic [CW-1:0] len_ext;
  logic [CW-1:0] last_idx;
  logic [CW-1:0] total;
  logic          wc_last;
  logic          pre_last;
  logic          sc_inc;
  logic          m_hs;

  assign len_ext  = {1'b0, len_q};
  assign last_idx = len_ext - ONE;
  assign total    = PRE_LEN + len_ext;
  assign wc_last  = (wc_q == last_idx);
  assign pre_last = (wc_q == PRE_LAST);
  assign m_hs     = m_axis_tvalid & m_axis_tready;

  // Symbol counter saturates so stray pulses cannot wrap it.
  assign sc_inc = sym_done && (state_q != ST_IDLE) && (sc_q < total);
  assign sc_d   = sc_q + CW'(sc_inc);

  assign busy      = busy_q;
  assign done      = done_q;
  assign short_err = short_err_q;

  // Stream outputs decode from state; payload is a zero-latency pass.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = 1'b0;
    unique case (state_q)
      ST_PREAMBLE: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = PREAMBLE_WORD;
        m_axis_tlast  = pre_last && (len_q == '0);
      end
      ST_PAYLOAD: begin
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = wc_last;
        s_axis_tready = m_axis_tready;
      end
      ST_PAD: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = PAD_WORD;
        m_axis_tlast  = wc_last;
      end
      default: ;
    endcase
    // Abort kills the transfer in flight so no word leaks out.
    if (abort) begin
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      s_axis_tready = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      wc_q        <= '0;
      sc_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      short_err_q <= 1'b0;
    end else if (abort) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      wc_q    <= '0;
      sc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      sc_q   <= sc_d;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_q       <= frame_len;
            wc_q        <= '0;
            sc_q        <= '0;
            short_err_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_PREAMBLE;
          end
        end
        ST_PREAMBLE: begin
          if (m_hs) begin
            if (pre_last) begin
              wc_q    <= '0;
              state_q <= (len_q == '0) ? ST_DRAIN
                                       : ST_PAYLOAD;
            end else begin
              wc_q <= wc_q + ONE;
            end
          end
        end
        ST_PAYLOAD: begin
          if (m_hs) begin
            if (wc_last) begin
              wc_q    <= '0;
              state_q <= ST_DRAIN;
            end else begin
              wc_q <= wc_q + ONE;
              if (s_axis_tlast) begin
                short_err_q <= 1'b1;
                state_q     <= ST_PAD;
              end
            end
          end
        end
        ST_PAD: begin
          if (m_hs) begin
            if (wc_last) begin
              wc_q    <= '0;
              state_q <= ST_DRAIN;
            end else begin
              wc_q <= wc_q + ONE;
            end
          end
        end
        ST_DRAIN: begin
          if (sc_d == total) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_ofdm_frame_ctrl.sv
// Scoreboard bench for axis_ofdm_frame_ctrl.
// Directed frames; a negedge monitor pops expected words and done events.
module tb_axis_ofdm_frame_ctrl;

  localparam logic [31:0] PW = 32'hA5A5_5A5A;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  frame_len = '0;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b1;
  logic        sym_done;
  logic        busy;
  logic        done;
  logic        short_err;

  always #5 aclk = ~aclk;

  axis_ofdm_frame_ctrl dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .start         (start),
    .abort         (abort),
    .frame_len     (frame_len),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .sym_done      (sym_done),
    .busy          (busy),
    .done          (done),
    .short_err     (short_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [32:0] exp_mem [128];
  int          exp_wr = 0;
  int          exp_rd = 0;
  logic [32:0] src_mem [128];
  int          src_wr = 0;
  int          src_rd = 0;

  int   done_exp = 0;
  int   done_seen = 0;
  int   s_ready_cnt = 0;
  logic m_hs_n = 1'b0;
  logic s_hs_n = 1'b0;
  logic sym_en = 1'b0;
  logic flush = 1'b0;
  int   pending = 0;

  logic        stall_q = 1'b0;
  logic [32:0] stall_w = '0;
  logic        prev_done = 1'b0;
  logic        prev_busy = 1'b0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  // Monitor: scoreboard pop on every downstream transfer.
  initial begin
    forever begin
      @(negedge aclk);
      m_hs_n = aresetn && m_axis_tvalid && m_axis_tready;
      s_hs_n = aresetn && s_axis_tvalid && s_axis_tready;
      if (aresetn) begin
        if (stall_q && !abort)
          chk("hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata},
              {1'b1, stall_w});
        if (m_hs_n) begin
          if (exp_rd >= exp_wr) begin
            bad("extra_word");
          end else begin
            chk("word", {m_axis_tlast, m_axis_tdata},
                exp_mem[exp_rd[6:0]]);
            exp_rd++;
          end
        end
        if (s_axis_tready) begin
          s_ready_cnt++;
          chk("s_ready_mirror", m_axis_tready, 1);
        end
        if (prev_done) chk("done_width", done, 0);
        if (done) begin
          if (done_seen >= done_exp) bad("unexpected_done");
          else chk("done_busy", {prev_busy, busy}, 2'b10);
          done_seen++;
        end
      end
      stall_q   = aresetn && m_axis_tvalid && !m_axis_tready;
      stall_w   = {m_axis_tlast, m_axis_tdata};
      prev_done = done;
      prev_busy = busy;
    end
  end

  // Upstream source and mapper model (one sym_done per word sent).
  initial begin
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    sym_done      = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      if (s_hs_n) src_rd++;
      if (!aresetn || flush) begin
        pending  = 0;
        sym_done = 1'b0;
      end else begin
        if (sym_done) pending--;
        if (m_hs_n) pending++;
        sym_done = sym_en && (pending > 0);
      end
      s_axis_tvalid = (src_rd < src_wr);
      {s_axis_tlast, s_axis_tdata} = src_mem[src_rd[6:0]];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_src(input logic l, input logic [31:0] d);
    src_mem[src_wr[6:0]] = {l, d};
    src_wr++;
  endtask

  task automatic push_exp(input logic l, input logic [31:0] d);
    exp_mem[exp_wr[6:0]] = {l, d};
    exp_wr++;
  endtask

  task automatic start_frame(input int len);
    frame_len = len[7:0];
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input bit toggle);
    int t0 = done_seen;
    int cyc = 0;
    while (done_seen == t0 && cyc < 300) begin
      if (toggle) m_axis_tready = ~m_axis_tready;
      tick();
      cyc++;
    end
    m_axis_tready = 1'b1;
    if (done_seen == t0) bad({nm, "_done_timeout"});
    chk({nm, "_all_sent"}, exp_rd, exp_wr);
    chk({nm, "_syms"}, pending, 0);
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_m_tvalid"}, m_axis_tvalid, 0);
    chk({t, "_s_tready"}, s_axis_tready, 0);
    chk({t, "_m_tlast"}, m_axis_tlast, 0);
    chk({t, "_m_tdata"}, m_axis_tdata, 0);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_done"}, done, 0);
    chk({t, "_short_err"}, short_err, 0);
  endtask

  initial begin
    int snap;
    int cyc;
    tick();
    chk_zero("reset");
    tick();
    aresetn = 1'b1;
    tick();
    sym_en = 1'b1;

    // Frame 1: len 3, full payload
    push_src(0, 32'hD0);
    push_src(0, 32'hD1);
    push_src(1, 32'hD2);
    push_exp(0, PW);
    push_exp(0, PW);
    push_exp(0, 32'hD0);
    push_exp(0, 32'hD1);
    push_exp(1, 32'hD2);
    done_exp++;
    start_frame(3);
    chk("f1_busy", busy, 1);
    wait_done("f1", 0);

    // Frame 2: len 0, preamble only
    snap = s_ready_cnt;
    push_exp(0, PW);
    push_exp(1, PW);
    done_exp++;
    start_frame(0);
    wait_done("f2", 0);
    chk("f2_no_s_ready", s_ready_cnt, snap);

    // Frame 3: len 4, upstream ends after two words
    push_src(0, 32'h11);
    push_src(1, 32'h22);
    push_exp(0, PW);
    push_exp(0, PW);
    push_exp(0, 32'h11);
    push_exp(0, 32'h22);
    push_exp(0, 32'h0);
    push_exp(1, 32'h0);
    done_exp++;
    start_frame(4);
    wait_done("f3", 0);
    chk("f3_short_err", short_err, 1);
    tick();
    chk("f3_short_sticky", short_err, 1);

    // Frame 4: len 4, downstream ready toggling
    push_src(0, 32'h31);
    push_src(0, 32'h32);
    push_src(0, 32'h33);
    push_src(1, 32'h34);
    push_exp(0, PW);
    push_exp(0, PW);
    push_exp(0, 32'h31);
    push_exp(0, 32'h32);
    push_exp(0, 32'h33);
    push_exp(1, 32'h34);
    done_exp++;
    start_frame(4);
    chk("f4_short_clr", short_err, 0);
    wait_done("f4", 1);

    // Frame 5: abort while second payload word is offered
    sym_en = 1'b0;
    push_src(0, 32'h41);
    push_src(0, 32'h42);
    push_src(0, 32'h43);
    push_src(1, 32'h44);
    push_exp(0, PW);
    push_exp(0, PW);
    push_exp(0, 32'h41);
    start_frame(4);
    cyc = 0;
    while (!(m_axis_tvalid && m_axis_tdata == 32'h42)
           && cyc < 50) begin
      tick();
      #1;
      cyc++;
    end
    if (cyc >= 50) bad("f5_wc1_timeout");
    abort = 1'b1;
    #1;
    chk("f5_abort_drop", {m_axis_tvalid, s_axis_tready}, 0);
    tick();
    abort = 1'b0;
    chk("f5_abort_busy", busy, 0);
    chk("f5_abort_idle", m_axis_tvalid, 0);
    tick();
    tick();
    tick();
    chk("f5_no_done", done_seen, done_exp);
    chk("f5_sent", exp_rd, exp_wr);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sym_en = 1'b1;
    push_exp(0, PW);
    push_exp(0, PW);
    push_exp(0, 32'h42);
    push_exp(0, 32'h43);
    push_exp(1, 32'h44);
    done_exp++;
    start_frame(3);
    wait_done("f5b", 0);

    // Frame 6: reset during DRAIN, then a fresh frame
    sym_en = 1'b0;
    push_src(1, 32'h50);
    push_exp(0, PW);
    push_exp(0, PW);
    push_exp(1, 32'h50);
    start_frame(1);
    cyc = 0;
    while (exp_rd < exp_wr && cyc < 50) begin
      tick();
      cyc++;
    end
    if (cyc >= 50) bad("f6_send_timeout");
    tick();
    tick();
    chk("f6_drain_busy", busy, 1);
    aresetn = 1'b0;
    #1;
    chk_zero("midrst");
    tick();
    tick();
    tick();
    aresetn = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sym_en = 1'b1;
    push_src(1, 32'h60);
    push_exp(0, PW);
    push_exp(0, PW);
    push_exp(1, 32'h60);
    done_exp++;
    start_frame(1);
    wait_done("f6", 0);

    tick();
    chk("done_count", done_seen, done_exp);
    chk("src_consumed", src_rd, src_wr);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_ofdm_frame_ctrl.md
Name: axis_ofdm_frame_ctrl

Overview:
Frame sequencer placed in front of the BPSK subcarrier mapper. On a start command it emits PREAMBLE_LEN fixed preamble words, then exactly frame_len payload words taken from the upstream AXI4-Stream. If the upstream ends early, it pads the frame to frame_len. It then counts completed 64-subcarrier symbols on the mapper output and reports frame completion. Each 32-bit word sent downstream becomes one OFDM symbol.

Parameters:
PREAMBLE_LEN, 2, number of preamble words per frame (1..15)
PREAMBLE_WORD, 32'hA5A5_5A5A, fixed preamble word
PAD_WORD, 32'h0000_0000, word substituted after an early upstream tlast
LEN_W, 8, width of frame_len and the payload counters

Ports:
aclk  in  1  clock
aresetn  in  1  reset; one clock domain, asynchronous active-low reset
start  in  1  single-cycle frame request; honoured only in IDLE
abort  in  1  synchronous abort; forces IDLE from any state
frame_len  in  LEN_W  payload word count; latched on accepted start
s_axis_tdata  in  32  payload from upstream
s_axis_tvalid  in  1  upstream valid
s_axis_tlast  in  1  upstream end-of-payload marker
s_axis_tready  out  1  upstream ready
m_axis_tdata  out  32  word to the mapper
m_axis_tvalid  out  1  valid to the mapper
m_axis_tlast  out  1  last word of the frame
m_axis_tready  in  1  mapper ready
sym_done  in  1  mapper output tlast&tvalid&tready; one pulse per finished symbol
busy  out  1  high from accepted start until done or abort
done  out  1  one-cycle pulse when all symbols have been mapped
short_err  out  1  sticky flag for early upstream tlast; cleared on the next accepted start

Behaviour:
- Reset values: state IDLE; all counters 0; s_axis_tready, m_axis_tvalid, m_axis_tlast, busy, done, short_err all 0; m_axis_tdata 0.
- States: IDLE, PREAMBLE, PAYLOAD, PAD, DRAIN, DONE.
- Handshake: a word transfers when tvalid&tready. m_axis_tvalid must not drop until its word transfers, except on abort.
- IDLE:
  - start=1 latches len=frame_len, clears the word counter wc, the symbol counter sc and short_err, and sets busy.
  - Next state is PREAMBLE.
- PREAMBLE:
  - m_axis_tvalid=1; tdata=PREAMBLE_WORD; s_axis_tready=0.
  - wc increments per handshake.
  - On the handshake with wc==PREAMBLE_LEN-1: go to PAYLOAD, or to DRAIN if len==0. In the len==0 case m_axis_tlast=1 on this word. wc resets to 0.
- PAYLOAD (combinational pass-through, zero latency):
  - m_axis_tdata=s_axis_tdata; m_axis_tvalid=s_axis_tvalid; s_axis_tready=m_axis_tready.
  - m_axis_tlast=1 when wc==len-1.
  - On the handshake with wc==len-1: go to DRAIN. Any upstream tlast on that word is ignored.
  - On a handshake with s_axis_tlast=1 and wc<len-1: set short_err and go to PAD.
  - Upstream words beyond len stay unconsumed for the next frame.
- PAD:
  - m_axis_tvalid=1; tdata=PAD_WORD; s_axis_tready=0.
  - Continues until wc==len-1, with m_axis_tlast on that word; then go to DRAIN.
- sc counts sym_done pulses in every non-IDLE state, saturating at PREAMBLE_LEN+len. Pulses that arrive in IDLE are ignored.
- DRAIN: all stream outputs deasserted. When sc==PREAMBLE_LEN+len, including in the same cycle as the increment that reaches it, go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle; then IDLE.
- start outside IDLE is ignored. start and abort together in IDLE: abort wins and the start is dropped.
- abort: next cycle is IDLE. All valids drop immediately and counters clear. short_err keeps its value. No done pulse.
- Async reset mid-frame returns everything to reset values immediately. The mapper must be reset alongside.
- Widths: wc and sc are LEN_W+1 bits. PREAMBLE_LEN+len is computed at LEN_W+1 bits with no overflow.

Decomposition:
- Shared package ofdm_pkg holds the state enum, the PREAMBLE_WORD/PAD_WORD defaults, and SYM_BITS=32 / N_SUBCAR=64 constants shared with the mapper.
- No sub-module needed; one FSM plus two counters.

Test Plan:
- PREAMBLE_LEN=2, frame_len=3, upstream D0..D2 with tlast on D2, tready=1 -> m_axis words A5A55A5A, A5A55A5A, D0, D1, D2; tlast only on D2; after 5 sym_done pulses, done pulses once and busy falls on the same cycle.
- frame_len=0 -> two preamble words, tlast on the second; s_axis_tready never asserted; done after 2 sym_done.
- frame_len=4, upstream tlast on second word -> output P,P,D0,D1,0,0; tlast on last pad word; short_err=1 until next start.
- m_axis_tready toggling 1010 during PAYLOAD -> no word lost or duplicated; tvalid held while tready=0; s_axis_tready mirrors m_axis_tready.
- abort asserted mid-PAYLOAD, wc=1 -> next cycle IDLE, busy=0, no done pulse; next start sends the full preamble again.
- aresetn pulsed low during DRAIN, then start with frame_len=1 -> all outputs 0 during reset; new frame completes after 3 sym_done pulses.
